// File: rtl/design_params_pkg.sv
// Shared bus geometry for the timer register bus and its masters.

package design_params_pkg;
    parameter int P_ADDR_WIDTH = 4;
    parameter int P_DATA_WIDTH = 16;
endpackage

// File: rtl/timer_bus_arbiter.sv
// Round-robin arbiter giving two masters access to the single timer register bus,
// with per-transfer timeout and a one-cycle release gap between transfers.

module timer_bus_arbiter #(
    parameter int P_ADDR_WIDTH = design_params_pkg::P_ADDR_WIDTH,
    parameter int P_DATA_WIDTH = design_params_pkg::P_DATA_WIDTH,
    parameter int P_TIMEOUT    = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    m0_req,
    input  logic [P_ADDR_WIDTH-1:0] m0_addr,
    input  logic [P_DATA_WIDTH-1:0] m0_wdata,
    input  logic                    m0_write_en,
    output logic                    m0_gnt,
    output logic [P_DATA_WIDTH-1:0] m0_rdata,
    input  logic                    m1_req,
    input  logic [P_ADDR_WIDTH-1:0] m1_addr,
    input  logic [P_DATA_WIDTH-1:0] m1_wdata,
    input  logic                    m1_write_en,
    output logic                    m1_gnt,
    output logic [P_DATA_WIDTH-1:0] m1_rdata,
    output logic                    t_req,
    output logic [P_ADDR_WIDTH-1:0] t_addr,
    output logic [P_DATA_WIDTH-1:0] t_wdata,
    output logic                    t_write_en,
    input  logic                    t_gnt,
    input  logic [P_DATA_WIDTH-1:0] t_rdata,
    output logic                    owner,
    output logic                    busy,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic       timeout_err_q, timeout_err_d;
    logic [3:0] cnt_q, cnt_d;

    logic [1:0]              req;
    logic [1:0]              gnt;
    logic [P_ADDR_WIDTH-1:0] addr  [2];
    logic [P_DATA_WIDTH-1:0] wdata [2];
    logic [1:0]              write_en;
    logic [P_DATA_WIDTH-1:0] rdata [2];
    logic                    in_busy;

    assign req      = {m1_req, m0_req};
    assign addr[0]  = m0_addr;
    assign addr[1]  = m1_addr;
    assign wdata[0] = m0_wdata;
    assign wdata[1] = m1_wdata;
    assign write_en = {m1_write_en, m0_write_en};
    assign in_busy  = (state_q == S_BUSY);

    // Grant and read data pass straight through from the timer: zero added latency.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            assign gnt[gi]   = in_busy && t_gnt && (owner_q == 1'(gi));
            assign rdata[gi] = gnt[gi] ? t_rdata : '0;
        end
    endgenerate

    assign m0_gnt      = gnt[0];
    assign m1_gnt      = gnt[1];
    assign m0_rdata    = rdata[0];
    assign m1_rdata    = rdata[1];
    assign t_req       = in_busy;
    assign t_addr      = in_busy ? addr[owner_q]     : '0;
    assign t_wdata     = in_busy ? wdata[owner_q]    : '0;
    assign t_write_en  = in_busy ? write_en[owner_q] : 1'b0;
    assign owner       = owner_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = timeout_err_q;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    owner_d = (req == 2'b11) ? rr_ptr_q : req[1];
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // A grant wins even if the owner abandons in the same cycle.
                if (t_gnt) begin
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (!req[owner_q]) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == 4'(P_TIMEOUT - 1)) begin
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                    state_d       = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RELEASE: begin
                rr_ptr_d = ~owner_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            owner_q       <= 1'b0;
            rr_ptr_q      <= 1'b0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Self-checking bench: timer peripheral model, per-transfer scoreboard and
// directed scenarios for arbitration, abort, timeout and reset.

module tb_timer_bus_arbiter;

    localparam int AW = design_params_pkg::P_ADDR_WIDTH;
    localparam int DW = design_params_pkg::P_DATA_WIDTH;
    localparam logic [AW-1:0] A_LOAD   = AW'(1);
    localparam logic [AW-1:0] A_STATUS = AW'(2);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          m0_req, m0_write_en, m0_gnt;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_write_en, m1_gnt;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          t_req, t_write_en, t_gnt;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, t_rdata;
    logic          owner, busy, timeout_err;

    timer_bus_arbiter #(.P_TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_write_en(m0_write_en), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_write_en(m1_write_en), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
        .t_req(t_req), .t_addr(t_addr), .t_wdata(t_wdata), .t_write_en(t_write_en),
        .t_gnt(t_gnt), .t_rdata(t_rdata),
        .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    logic [63:0] all_out;
    assign all_out = 64'({m0_gnt, m1_gnt, m0_rdata, m1_rdata, t_req, t_addr,
                          t_wdata, t_write_en, owner, busy, timeout_err});

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic          master;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          we;
        logic [DW-1:0] rdata;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    // Timer peripheral model
    int            gnt_delay;
    bit            timer_dead;
    bit            spurious_gnt;
    logic [DW-1:0] load_reg;
    logic [DW-1:0] status_reg;
    int            req_cycles = 0;

    initial begin
        t_gnt   = 1'b0;
        t_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (t_req && !timer_dead && req_cycles == gnt_delay) begin
                t_gnt   = 1'b1;
                t_rdata = (t_addr == A_STATUS) ? status_reg : load_reg;
                if (t_write_en && t_addr == A_LOAD) load_reg = t_wdata;
            end else begin
                t_gnt   = spurious_gnt && !t_req;
                t_rdata = DW'($urandom);
            end
            req_cycles = t_req ? req_cycles + 1 : 0;
        end
    end

    // Scoreboard monitor and per-cycle invariants
    initial begin
        forever begin
            @(negedge clk);
            check("gnt_onehot", 64'(m0_gnt & m1_gnt), 64'(0));
            check("treq_outside_busy", 64'(t_req & ~busy), 64'(0));
            check("gnt_without_tgnt", 64'((m0_gnt | m1_gnt) & ~(t_gnt & t_req)), 64'(0));
            check("m0_rdata_gated", 64'(m0_gnt ? {DW{1'b0}} : m0_rdata), 64'(0));
            check("m1_rdata_gated", 64'(m1_gnt ? {DW{1'b0}} : m1_rdata), 64'(0));
            if (m0_gnt || m1_gnt) begin
                check("sb_expected", 64'(sb_q.size() > 0), 64'(1));
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    check("sb_master", 64'(m1_gnt), 64'(mon_e.master));
                    check("sb_addr", 64'(t_addr), 64'(mon_e.addr));
                    check("sb_we", 64'(t_write_en), 64'(mon_e.we));
                    if (mon_e.we)
                        check("sb_wdata", 64'(t_wdata), 64'(mon_e.wdata));
                    else
                        check("sb_rdata", 64'(mon_e.master ? m1_rdata : m0_rdata), 64'(mon_e.rdata));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic set_master(input int m, input logic req, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic we);
        if (m == 0) begin
            m0_req = req; m0_addr = addr; m0_wdata = wdata; m0_write_en = we;
        end else begin
            m1_req = req; m1_addr = addr; m1_wdata = wdata; m1_write_en = we;
        end
    endtask

    task automatic issue(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic we, input logic [DW-1:0] rdata);
        exp_t e;
        e.master = 1'(m); e.addr = addr; e.wdata = wdata; e.we = we; e.rdata = rdata;
        sb_q.push_back(e);
        set_master(m, 1'b1, addr, wdata, we);
    endtask

    task automatic drop(input int m);
        if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where the grant is visible.
    task automatic wait_gnt(input int m, input int bound);
        int n = 0;
        while (((m == 0) ? m0_gnt : m1_gnt) !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("gnt%0d_seen", m), 64'((m == 0) ? m0_gnt : m1_gnt), 64'(1));
    endtask

    task automatic release_after_gnt(input int m);
        @(posedge clk); #1;
        drop(m);
    endtask

    // Returns at posedge+1 of an idle cycle.
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 64'(busy), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        bit err_early;
        reset_n      = 1'b0;
        set_master(0, 1'b0, '0, '0, 1'b0);
        set_master(1, 1'b0, '0, '0, 1'b0);
        gnt_delay    = 0;
        timer_dead   = 0;
        spurious_gnt = 0;
        status_reg   = DW'(1);
        load_reg     = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_out, 64'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Single write of LOAD by m0
        @(posedge clk); #1;
        gnt_delay = 2;
        issue(0, A_LOAD, 16'h0010, 1'b1, '0);
        @(negedge clk);
        check("wr_no_treq_yet", 64'(t_req), 64'(0));
        @(negedge clk);
        check("wr_treq_lat1", 64'(t_req), 64'(1));
        check("wr_owner", 64'(owner), 64'(0));
        check("wr_busy", 64'(busy), 64'(1));
        check("wr_addr_b0", 64'(t_addr), 64'(A_LOAD));
        check("wr_wdata", 64'(t_wdata), 64'(16'h0010));
        check("wr_we", 64'(t_write_en), 64'(1));
        @(negedge clk);
        check("wr_addr_b1", 64'(t_addr), 64'(A_LOAD));
        check("wr_no_early_gnt", 64'(m0_gnt), 64'(0));
        @(negedge clk);
        check("wr_gnt", 64'(m0_gnt), 64'(1));
        check("wr_addr_b2", 64'(t_addr), 64'(A_LOAD));
        release_after_gnt(0);
        @(negedge clk);
        check("wr_release_treq", 64'(t_req), 64'(0));
        check("wr_release_busy", 64'(busy), 64'(1));
        check("wr_gnt_one_cycle", 64'(m0_gnt), 64'(0));
        @(negedge clk);
        check("wr_back_idle", 64'(busy), 64'(0));
        check("wr_load_reg", 64'(load_reg), 64'(16'h0010));
        @(posedge clk); #1;

        // m1 reads STATUS (timer expired)
        gnt_delay = 1;
        issue(1, A_STATUS, '0, 1'b0, DW'(1));
        @(negedge clk);
        wait_gnt(1, 20);
        check("rd_m1_rdata", 64'(m1_rdata), 64'(1));
        check("rd_m0_rdata", 64'(m0_rdata), 64'(0));
        check("rd_no_timeout", 64'(timeout_err), 64'(0));
        release_after_gnt(1);
        wait_idle();

        // Contention straight after reset
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        gnt_delay = 0;
        issue(0, A_STATUS, '0, 1'b0, DW'(1));
        issue(1, A_LOAD, '0, 1'b0, 16'h0010);
        @(negedge clk);
        wait_gnt(0, 20);
        check("ct_first_owner", 64'(owner), 64'(0));
        release_after_gnt(0);
        n = 0;
        @(negedge clk);
        while (!t_req && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("ct_treq_gap", 64'(n), 64'(2));
        check("ct_second_owner", 64'(owner), 64'(1));
        wait_gnt(1, 20);
        release_after_gnt(1);
        wait_idle();

        issue(0, A_LOAD, 16'h0010, 1'b1, '0);
        issue(1, A_STATUS, '0, 1'b0, DW'(1));
        @(negedge clk);
        wait_gnt(0, 20);
        check("ct_repeat_owner", 64'(owner), 64'(0));
        release_after_gnt(0);
        @(negedge clk);
        wait_gnt(1, 20);
        release_after_gnt(1);
        wait_idle();

        // Abort by m0 with m1 pending
        gnt_delay = 5;
        set_master(0, 1'b1, A_LOAD, 16'h0BAD, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("ab_treq", 64'(t_req), 64'(1));
        @(posedge clk); #1;
        drop(0);
        issue(1, A_STATUS, '0, 1'b0, DW'(1));
        @(negedge clk);
        @(negedge clk);
        check("ab_treq_drop", 64'(t_req), 64'(0));
        check("ab_idle", 64'(busy), 64'(0));
        @(negedge clk);
        check("ab_m1_next", 64'(owner), 64'(1));
        check("ab_m1_treq", 64'(t_req), 64'(1));
        wait_gnt(1, 20);
        check("ab_no_write", 64'(load_reg), 64'(16'h0010));
        release_after_gnt(1);
        wait_idle();

        // Abort by m1 must not move rr_ptr (primed to 1 by an m0 transfer)
        gnt_delay = 0;
        issue(0, A_STATUS, '0, 1'b0, DW'(1));
        @(negedge clk);
        wait_gnt(0, 20);
        release_after_gnt(0);
        wait_idle();
        gnt_delay = 5;
        set_master(1, 1'b1, A_LOAD, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("ab2_owner", 64'(owner), 64'(1));
        @(posedge clk); #1;
        drop(1);
        @(posedge clk); #1;
        issue(1, A_LOAD, '0, 1'b0, 16'h0010);
        issue(0, A_STATUS, '0, 1'b0, DW'(1));
        @(negedge clk);
        check("ab2_idle", 64'(busy), 64'(0));
        @(negedge clk);
        check("ab2_rr_kept", 64'(owner), 64'(1));
        wait_gnt(1, 20);
        release_after_gnt(1);
        @(negedge clk);
        wait_gnt(0, 30);
        release_after_gnt(0);
        wait_idle();

        // Owner drops req in the same cycle as t_gnt
        gnt_delay = 1;
        issue(0, A_LOAD, '0, 1'b0, 16'h0010);
        @(negedge clk);
        @(negedge clk);
        check("dg_treq", 64'(t_req), 64'(1));
        @(posedge clk); #1;
        drop(0);
        @(negedge clk);
        check("dg_gnt_fwd", 64'(m0_gnt), 64'(1));
        check("dg_rdata", 64'(m0_rdata), 64'(16'h0010));
        @(negedge clk);
        check("dg_release", 64'(busy), 64'(1));
        check("dg_release_treq", 64'(t_req), 64'(0));
        wait_idle();

        // Spurious t_gnt while idle
        spurious_gnt = 1;
        @(negedge clk);
        @(negedge clk);
        check("sp_no_gnt", 64'({m0_gnt, m1_gnt}), 64'(0));
        check("sp_idle", 64'(busy), 64'(0));
        spurious_gnt = 0;
        @(posedge clk); #1;

        // Timeout: timer never answers
        timer_dead = 1;
        set_master(0, 1'b1, A_LOAD, 16'hDEAD, 1'b1);
        n = 0;
        @(negedge clk);
        while (!t_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        err_early = 0;
        while (t_req && n < 20) begin
            err_early |= timeout_err;
            n++;
            @(negedge clk);
        end
        check("to_busy_cycles", 64'(n), 64'(8));
        check("to_no_early_err", 64'(err_early), 64'(0));
        check("to_err_pulse", 64'(timeout_err), 64'(1));
        check("to_release_busy", 64'(busy), 64'(1));
        check("to_no_gnt", 64'({m0_gnt, m1_gnt}), 64'(0));
        @(posedge clk); #1;
        drop(0);
        @(negedge clk);
        check("to_err_once", 64'(timeout_err), 64'(0));
        check("to_back_idle", 64'(busy), 64'(0));
        check("to_no_write", 64'(load_reg), 64'(16'h0010));
        @(posedge clk); #1;

        // Reset asserted mid-BUSY
        set_master(1, 1'b1, A_STATUS, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rm_busy", 64'(t_req), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("rm_async_zero", all_out, 64'(0));
        issue(0, A_STATUS, '0, 1'b0, DW'(1));
        issue(1, A_STATUS, '0, 1'b0, DW'(1));
        @(negedge clk);
        check("rm_hold_zero", all_out, 64'(0));
        timer_dead = 0;
        gnt_delay  = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rm_idle_at_release", 64'(t_req), 64'(0));
        @(negedge clk);
        check("rm_first_edge_arb", 64'(t_req), 64'(1));
        check("rm_rr_reset", 64'(owner), 64'(0));
        wait_gnt(0, 20);
        release_after_gnt(0);
        @(negedge clk);
        wait_gnt(1, 20);
        release_after_gnt(1);
        wait_idle();

        check("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/timer_bus_arbiter.md
TIMER_BUS_ARBITER -- requirements
Module: timer_bus_arbiter

Interface
REQ-001 The block SHALL import design_params_pkg and take its parameters from it: P_ADDR_WIDTH, package default, address width; P_DATA_WIDTH, package default, data width.
REQ-002 The block SHALL have parameter P_TIMEOUT, default 8, the number of BUSY cycles without t_gnt before abort; legal range is 2..15.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 mN_req  in  1  request from master N (N = 0,1); held high until mN_gnt or until the master abandons.
REQ-006 mN_addr  in  P_ADDR_WIDTH  register address from master N; stable while mN_req is high.
REQ-007 mN_wdata  in  P_DATA_WIDTH  write data from master N.
REQ-008 mN_write_en  in  1  1 = write, 0 = read, from master N.
REQ-009 mN_gnt  out  1  one-cycle completion pulse to master N.
REQ-010 mN_rdata  out  P_DATA_WIDTH  read data to master N; valid while mN_gnt is high, 0 otherwise.
REQ-011 t_req / t_addr / t_wdata / t_write_en  out  1 / P_ADDR_WIDTH / P_DATA_WIDTH / 1  request bus to the timer peripheral.
REQ-012 t_gnt / t_rdata  in  1 / P_DATA_WIDTH  one-cycle grant and read data from the timer; both are valid in the same cycle.
REQ-013 owner  out  1  index of the master currently selected; meaningful only while busy = 1.
REQ-014 busy  out  1  high in states BUSY and RELEASE.
REQ-015 timeout_err  out  1  one-cycle pulse when a transaction is aborted by timeout.

Function
REQ-016 The FSM SHALL have three states: IDLE, BUSY and RELEASE.
REQ-017 IDLE: if any mN_req is high, the FSM SHALL register owner and go to BUSY on the next edge; otherwise it SHALL stay in IDLE.
REQ-018 Selection SHALL be round-robin via rr_ptr: if only one master requests, that master wins; if both request, master rr_ptr wins.
REQ-019 t_req SHALL be high exactly while in BUSY; t_addr, t_wdata and t_write_en SHALL be the owner's inputs while in BUSY and 0 otherwise.
REQ-020 BUSY with t_gnt = 1: the block SHALL drive m[owner]_gnt = 1 and m[owner]_rdata = t_rdata combinationally in the same cycle (zero added latency), then go to RELEASE.
REQ-021 BUSY with the owner's req low and t_gnt = 0: the block SHALL treat it as an abort, go to IDLE with no gnt, and leave rr_ptr unchanged.
REQ-022 BUSY with the owner's req low and t_gnt = 1 in the same cycle: gnt SHALL still be forwarded; the transfer counts as complete.
REQ-023 A BUSY-cycle counter SHALL reset on entry to BUSY; when it reaches P_TIMEOUT with no t_gnt, the block SHALL pulse timeout_err for 1 cycle, give no mN_gnt, and go to RELEASE.
REQ-024 RELEASE SHALL last exactly 1 cycle with t_req = 0, so the timer handshake returns to idle.
REQ-025 On leaving RELEASE, rr_ptr SHALL become ~owner, and the FSM SHALL go to IDLE.
REQ-026 Minimum request-to-t_req latency SHALL be 1 cycle, and back-to-back transfers SHALL be separated by at least 2 cycles of t_req low (RELEASE + IDLE).
REQ-027 The non-owner's gnt SHALL be 0 at all times and its rdata SHALL be 0; a non-owner request SHALL wait and SHALL NOT be dropped.
REQ-028 The block SHALL never grant two masters in the same cycle and SHALL never assert t_req outside BUSY.
REQ-029 When t_gnt = 1 outside BUSY (spurious), the block SHALL ignore it, with no mN_gnt.

Reset
REQ-030 While reset_n = 0, the block SHALL hold state = IDLE, rr_ptr = 0, owner = 0, timeout counter = 0, and all outputs = 0.
REQ-031 Reset asserted mid-transaction SHALL force IDLE immediately (asynchronously), with t_req and all gnt dropped the same instant.
REQ-032 After reset release, the first arbitration SHALL occur on the first rising edge with reset_n = 1.

Verification
REQ-033 Scenario, single write: m0 write LOAD = 16'h0010 -> t_req high 1 cycle after m0_req; m0_gnt is 1 cycle coincident with t_gnt; RELEASE follows; t_addr = LOAD throughout.
REQ-034 Scenario, contention: m0 and m1 request in the same cycle after reset -> m0 served first, then m1 (rr_ptr = 1); a repeat contention is then served m0 first again.
REQ-035 Scenario, read pass-through: m1 reads STATUS with the timer expired -> m1_rdata = 1 during m1_gnt, m0_rdata = 0, and timeout_err = 0.
REQ-036 Scenario, abort: m0 drops req 1 cycle into BUSY, before t_gnt -> t_req drops next cycle, no gnt, rr_ptr is still 0, and a pending m1 is served next.
REQ-037 Scenario, timeout: the timer model never asserts t_gnt -> timeout_err pulses after 8 BUSY cycles, then 1 RELEASE cycle, with no mN_gnt.
REQ-038 Scenario, reset mid-BUSY: reset_n pulsed low while t_req = 1 -> all outputs 0 immediately, and after release the next request starts with rr_ptr = 0.
